expr_truth_table_scanner: RTL

- Sequencer for the 3-input gate-level expression evaluator, o = (a&c) & ((~a&b) | (a&b&~c)).
- On a start pulse it sweeps all 8 input vectors {a,b,c} = 0..7 through the evaluator and waits a programmable settle time per vector.
- It samples o into an 8-bit truth table and compares the table against a golden value.
- It sits beside the evaluator instance, which is wired externally, so a bench or BIST wrapper can self-check the datapath.

---
 rtl/expr_scan_pkg.sv | 16 +
 rtl/scan_settle_timer.sv | 28 ++
 rtl/expr_truth_table_scanner.sv | 118 +++++++++++
 3 files changed

// File: rtl/expr_scan_pkg.sv
// Shared constants and state encoding for the truth-table sweep controller.
// Latency: n/a (package); backpressure: n/a.
package expr_scan_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  // The evaluated expression reduces to constant 0, so every golden bit is 0.
  localparam logic [NUM_VECTORS-1:0] EXPECTED_TABLE_DEFAULT = 8'h00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/scan_settle_timer.sv
// Loadable down-counter; expired is high whenever the count sits at zero.
// Latency: load takes effect on the next edge; backpressure: none.
module scan_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/expr_truth_table_scanner.sv
// Sweeps {a,b,c} = 0..7 through an external evaluator, captures o, compares to golden.
// Latency: done in cycle 8*(SETTLE_CYCLES+1)+1 after start; backpressure: start ignored while busy.
module expr_truth_table_scanner
  import expr_scan_pkg::*;
#(
  parameter int                         SETTLE_CYCLES  = 1,
  parameter logic [NUM_VECTORS-1:0]     EXPECTED_TABLE = EXPECTED_TABLE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   eval_a,
  output logic                   eval_b,
  output logic                   eval_c,
  input  logic                   eval_o,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] truth_table,
  output logic                   mismatch,
  output logic [3:0]             fail_count,
  output logic [VEC_W-1:0]       first_fail
);

  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);
  localparam logic [3:0]       SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  // With no settle time each vector is sampled in the cycle right after it is driven.
  localparam logic [1:0]       VEC_ENTRY   = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  logic [1:0]             state;
  logic [VEC_W-1:0]       vec_idx;
  logic                   tmr_load;
  logic                   tmr_expired;
  logic [NUM_VECTORS-1:0] final_table;
  logic [NUM_VECTORS-1:0] diff;
  logic [3:0]             diff_cnt;
  logic [VEC_W-1:0]       diff_first;

  assign tmr_load = ((state == ST_IDLE) && start) ||
                    ((state == ST_SAMPLE) && !abort && (vec_idx != LAST_VEC));

  scan_settle_timer #(.W(4)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (state == ST_SETTLE),
    .load_val (SETTLE_LOAD),
    .expired  (tmr_expired)
  );

  // Table as it will look after this SAMPLE capture; only consumed on the last vector.
  always_comb begin
    final_table          = truth_table;
    final_table[vec_idx] = eval_o;
    diff                 = final_table ^ EXPECTED_TABLE;
    diff_cnt             = '0;
    diff_first           = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      diff_cnt = diff_cnt + {3'b000, diff[i]};
    end
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (diff[i]) diff_first = VEC_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      vec_idx     <= '0;
      truth_table <= '0;
      mismatch    <= 1'b0;
      fail_count  <= '0;
      first_fail  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= VEC_ENTRY;
            vec_idx     <= '0;
            truth_table <= '0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (tmr_expired) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            truth_table[vec_idx] <= eval_o;
            if (vec_idx == LAST_VEC) begin
              state      <= ST_DONE;
              mismatch   <= |diff;
              fail_count <= diff_cnt;
              first_fail <= diff_first;
            end else begin
              vec_idx <= vec_idx + 1'b1;
              state   <= VEC_ENTRY;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign eval_a = vec_idx[2];
  assign eval_b = vec_idx[1];
  assign eval_c = vec_idx[0];

endmodule
